// File: rtl/mod_n_updown_counter.sv
// Parametrised modulo-MOD up/down counter with clear, clamped parallel load and cascade carry.
// Latency: data_o, wrap_o and load_err_o are registered one edge after their inputs; tc_o is combinational.
// Backpressure: none; an operation is accepted on every edge, chained stages gate each other through en_i.
module mod_n_updown_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             up_dn_i,
    output logic [WIDTH-1:0] data_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             load_err_o
);

    if (WIDTH < 1 || MOD < 2 || longint'(MOD) > (longint'(1) << WIDTH)) begin : g_bad_param
        $error("mod_n_updown_counter: need WIDTH >= 1 and 2 <= MOD <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             lerr_q, lerr_d;
    logic             at_max;
    logic             at_zero;
    logic             count_ok;

    assign at_max   = (cnt_q == MAX_V);
    assign at_zero  = (cnt_q == '0);
    assign count_ok = en_i & ~rst_i & ~clear_i & ~load_i;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        lerr_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            if (load_val_i > MAX_V) begin
                cnt_d  = MAX_V;
                lerr_d = 1'b1;
            end else begin
                cnt_d = load_val_i;
            end
        end else if (en_i) begin
            if (up_dn_i) begin
                // >= rather than == so an out-of-range value still recovers to 0
                if (cnt_q >= MAX_V) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    cnt_d  = MAX_V;
                    wrap_d = 1'b1;
                end else if (cnt_q > MAX_V) begin
                    cnt_d = MAX_V;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            lerr_q <= lerr_d;
        end
    end

    assign data_o     = cnt_q;
    assign wrap_o     = wrap_q;
    assign load_err_o = lerr_q;
    // Carry is raised ahead of the wrapping edge so a stage fed by it advances on that same edge
    assign tc_o       = count_ok & ((up_dn_i & at_max) | (~up_dn_i & at_zero));

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter: directed vector table, two-stage cascade, randomized run vs reference model.
// Inputs change 1ns after the rising edge; tc_o is sampled just before the edge, registered outputs just after.
module tb_mod_n_updown_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr, ld, en, up;
    logic [3:0] lv;
    logic [2:0] lv8;
    logic [3:0] d10;
    logic [2:0] d8;
    logic       tc10, wr10, le10, tc8, wr8, le8;

    logic       cas_rst, cas_en;
    logic [3:0] c0_d, c1_d;
    logic       c0_tc, c0_wr, c0_le, c1_tc, c1_wr, c1_le;

    int vectors = 0;
    int miscompares = 0;

    mod_n_updown_counter #(.WIDTH(4), .MOD(10)) u10 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .load_i(ld), .load_val_i(lv),
        .en_i(en), .up_dn_i(up), .data_o(d10), .tc_o(tc10), .wrap_o(wr10), .load_err_o(le10)
    );

    mod_n_updown_counter #(.WIDTH(3), .MOD(8)) u8 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .load_i(ld), .load_val_i(lv8),
        .en_i(en), .up_dn_i(up), .data_o(d8), .tc_o(tc8), .wrap_o(wr8), .load_err_o(le8)
    );

    mod_n_updown_counter #(.WIDTH(4), .MOD(10)) c0 (
        .clk_i(clk), .rst_i(cas_rst), .clear_i(1'b0), .load_i(1'b0), .load_val_i(4'd0),
        .en_i(cas_en), .up_dn_i(1'b1), .data_o(c0_d), .tc_o(c0_tc), .wrap_o(c0_wr), .load_err_o(c0_le)
    );

    mod_n_updown_counter #(.WIDTH(4), .MOD(10)) c1 (
        .clk_i(clk), .rst_i(cas_rst), .clear_i(1'b0), .load_i(1'b0), .load_val_i(4'd0),
        .en_i(c0_tc), .up_dn_i(1'b1), .data_o(c1_d), .tc_o(c1_tc), .wrap_o(c1_wr), .load_err_o(c1_le)
    );

    typedef struct {
        bit rst, clr, ld;
        int lv;
        bit en, up;
        int e_tc, e_data, e_wrap, e_lerr;
    } vec_t;

    vec_t tbl[64];
    int   n_tbl = 0;

    typedef struct {
        int cnt;
        bit wrap;
        bit lerr;
    } mst_t;

    task automatic add(input bit r, input bit c, input bit l, input int v, input bit e, input bit u,
                       input int tc, input int dat, input int wr, input int le);
        tbl[n_tbl] = '{r, c, l, v, e, u, tc, dat, wr, le};
        n_tbl++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic mst_t ref_next(int m, int cnt, bit r, bit c, bit l, int v, bit e, bit u);
        mst_t s;
        s.cnt = cnt; s.wrap = 1'b0; s.lerr = 1'b0;
        if (r || c) s.cnt = 0;
        else if (l) begin
            if (v < m) s.cnt = v;
            else begin s.cnt = m - 1; s.lerr = 1'b1; end
        end else if (e) begin
            if (u) begin s.cnt = (cnt + 1) % m; s.wrap = (cnt == m - 1); end
            else   begin s.cnt = (cnt + m - 1) % m; s.wrap = (cnt == 0); end
        end
        return s;
    endfunction

    function automatic bit ref_tc(int m, int cnt, bit r, bit c, bit l, bit e, bit u);
        return e && !r && !c && !l && (u ? (cnt == m - 1) : (cnt == 0));
    endfunction

    task automatic drive(input bit r, input bit c, input bit l, input int v, input bit e, input bit u);
        rst = r; clr = c; ld = l; lv = 4'(v); lv8 = 3'(v); en = e; up = u;
    endtask

    initial begin
        mst_t s10, s8;
        int   m10, m8;
        bit   r, c, l, e, u;
        int   v;

        drive(0, 0, 0, 0, 0, 1);
        cas_rst = 1'b0; cas_en = 1'b0;

        // Reset, then 12 up-count edges: 0..9,0,1 with carry while at 9
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        for (int k = 1; k <= 12; k++)
            add(0, 0, 0, 0, 1, 1, ((k - 1) % 10 == 9) ? 1 : 0, k % 10, (k == 10) ? 1 : 0, 0);
        // Load 2 then count down through the 0 -> 9 wrap
        add(0, 0, 1, 2, 0, 0,  0, 2, 0, 0);
        add(0, 0, 0, 0, 1, 0,  0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0,  0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0,  1, 9, 1, 0);
        add(0, 0, 0, 0, 1, 0,  0, 8, 0, 0);
        // Clamped load, then in-range load
        add(0, 0, 1, 13, 1, 1, 0, 9, 0, 1);
        add(0, 0, 1, 5, 0, 0,  0, 5, 0, 0);
        // Clear beats load and count at 9
        add(0, 0, 1, 9, 0, 0,  0, 9, 0, 0);
        add(0, 1, 1, 3, 1, 1,  0, 0, 0, 0);
        // Reset beats everything and drops a pending load error
        add(0, 0, 1, 13, 0, 0, 0, 9, 0, 1);
        add(1, 1, 1, 3, 1, 1,  0, 0, 0, 0);
        // Idle clears a load error pulse
        add(0, 0, 1, 15, 0, 1, 0, 9, 0, 1);
        add(0, 0, 0, 0, 0, 1,  0, 9, 0, 0);
        // Wrap pulse is dropped by a following clear
        add(0, 0, 0, 0, 1, 1,  1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1,  0, 0, 0, 0);
        // Hold at 4, then flip direction every enabled edge
        add(0, 0, 1, 4, 0, 1,  0, 4, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 1, 0, 4, 0, 0);
        add(0, 0, 0, 0, 1, 1,  0, 5, 0, 0);
        add(0, 0, 0, 0, 1, 0,  0, 4, 0, 0);
        add(0, 0, 0, 0, 1, 1,  0, 5, 0, 0);
        add(0, 0, 0, 0, 1, 0,  0, 4, 0, 0);

        @(posedge clk); #1;
        for (int i = 0; i < n_tbl; i++) begin
            drive(tbl[i].rst, tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].up);
            #3;
            chk($sformatf("vec%0d tc_o", i), int'(tc10), tbl[i].e_tc);
            @(posedge clk); #1;
            chk($sformatf("vec%0d data_o", i), int'(d10), tbl[i].e_data);
            chk($sformatf("vec%0d wrap_o", i), int'(wr10), tbl[i].e_wrap);
            chk($sformatf("vec%0d load_err_o", i), int'(le10), tbl[i].e_lerr);
        end

        // Two-digit cascade: stage 1 advances on stage 0 carry in the same edge
        cas_rst = 1'b1;
        @(posedge clk); #1;
        cas_rst = 1'b0;
        chk("cascade reset", int'(c1_d) * 10 + int'(c0_d), 0);
        cas_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            chk($sformatf("cascade edge%0d value", k), int'(c1_d) * 10 + int'(c0_d), k % 100);
            chk($sformatf("cascade edge%0d stage1 wrap", k), int'(c1_wr), (k == 100) ? 1 : 0);
        end
        cas_en = 1'b0;

        // Randomized run on MOD=10 and MOD=8 (natural binary wrap) against the reference model
        m10 = 0; m8 = 0;
        for (int k = 0; k < 400; k++) begin
            r = (k == 0) || ($urandom_range(31) == 0);
            c = ($urandom_range(15) == 0);
            l = ($urandom_range(7) == 0);
            v = int'($urandom_range(15));
            e = ($urandom_range(3) != 0);
            u = 1'($urandom_range(1));
            drive(r, c, l, v, e, u);
            #3;
            chk($sformatf("rnd%0d mod10 tc_o", k), int'(tc10), int'(ref_tc(10, m10, r, c, l, e, u)));
            chk($sformatf("rnd%0d mod8 tc_o", k), int'(tc8), int'(ref_tc(8, m8, r, c, l, e, u)));
            s10 = ref_next(10, m10, r, c, l, v, e, u);
            s8  = ref_next(8, m8, r, c, l, v % 8, e, u);
            m10 = s10.cnt; m8 = s8.cnt;
            @(posedge clk); #1;
            chk($sformatf("rnd%0d mod10 data_o", k), int'(d10), s10.cnt);
            chk($sformatf("rnd%0d mod10 wrap_o", k), int'(wr10), int'(s10.wrap));
            chk($sformatf("rnd%0d mod10 load_err_o", k), int'(le10), int'(s10.lerr));
            chk($sformatf("rnd%0d mod8 data_o", k), int'(d8), s8.cnt);
            chk($sformatf("rnd%0d mod8 wrap_o", k), int'(wr8), int'(s8.wrap));
            chk($sformatf("rnd%0d mod8 load_err_o", k), int'(le8), int'(s8.lerr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
- Parametrised synchronous modulo-N up/down counter. Successor to the fixed mod-10 up counter.
- Adds parametrised width and modulus, direction control, count enable, synchronous clear, parallel load with range clamp, and cascade/wrap outputs.
- Used standalone as a programmable divider/counter, or chained: tc_o of one stage drives en_i of the next, which builds multi-digit BCD or mixed-radix counters.

Parameters:
- WIDTH, 4, counter width in bits; minimum 1.
- MOD, 10, modulus; count range is 0..MOD-1. Legal range is 2 <= MOD <= 2**WIDTH. An illegal value triggers an elaboration-time error.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- clear_i  input  1  synchronous clear to 0.
- load_i  input  1  parallel load strobe.
- load_val_i  input  WIDTH  value to load.
- en_i  input  1  count enable.
- up_dn_i  input  1  direction; 1 = up, 0 = down.
- data_o  output  WIDTH  current count, registered.
- tc_o  output  1  terminal count / cascade carry, combinational.
- wrap_o  output  1  registered one-cycle pulse: the counter wrapped on the previous edge.
- load_err_o  output  1  registered one-cycle pulse: the previous load was out of range and was clamped.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock is clk_i, reset is rst_i; no other clock domains.
- Reset (rst_i=1 at a rising edge):
  - data_o=0, wrap_o=0, load_err_o=0.
  - rst_i overrides all other inputs.
- Priority per edge: rst_i > clear_i > load_i > en_i. Only the highest active operation takes effect.
- clear_i:
  - data_o <= 0.
  - wrap_o <= 0, load_err_o <= 0.
- load_i:
  - If load_val_i <= MOD-1: data_o <= load_val_i, load_err_o <= 0.
  - Otherwise: data_o <= MOD-1, load_err_o <= 1.
  - wrap_o <= 0.
  - Load is independent of en_i and up_dn_i.
- Count (en_i=1, no higher-priority op):
  - Up: data_o >= MOD-1 -> 0 with wrap_o <= 1; else data_o+1 with wrap_o <= 0.
  - Down: data_o == 0 -> MOD-1 with wrap_o <= 1. data_o > MOD-1 (unreachable, defensive) -> MOD-1 with wrap_o <= 0. Else data_o-1 with wrap_o <= 0.
  - load_err_o <= 0.
- Idle (en_i=0, no other op):
  - data_o holds.
  - wrap_o <= 0, load_err_o <= 0.
- tc_o:
  - tc_o = en_i & ~rst_i & ~clear_i & ~load_i & ((up_dn_i & data_o==MOD-1) | (~up_dn_i & data_o==0)).
  - Asserts in the same cycle as the edge that will wrap. This lets a downstream stage enabled by tc_o advance on that same edge, with zero-cycle carry propagation.
- Direction change: takes effect on the next enabled edge; there is no pipeline.
- Latency: data_o updates one edge after its control inputs. wrap_o and load_err_o lag data_o's triggering edge by 0 cycles (registered on the same edge); they are valid for exactly one cycle.
- MOD == 2**WIDTH: natural binary wrap; no compare-induced gap.
- Reset asserted mid-count, or together with load/clear: reset wins and all outputs go to 0 on that edge.

Test Plan:
- Reset then up-count (MOD=10, WIDTH=4): rst_i=1 one edge, then en_i=1, up_dn_i=1 for 12 edges.
  - Required: data_o 0,1,...,9,0,1.
  - wrap_o high only in the cycle after 9->0.
  - tc_o high only while data_o=9.
- Down-count wrap: load 2, then en_i=1, up_dn_i=0 for 4 edges.
  - Required: data_o 2,1,0,9,8.
  - wrap_o pulses after 0->9.
  - tc_o high while data_o=0.
- Load clamp: load_i=1, load_val_i=13.
  - Required: data_o=9, load_err_o=1 for one cycle.
  - Then load_val_i=5: data_o=5, load_err_o=0.
- Priority: data_o=9 with en_i=1, load_i=1, load_val_i=3, clear_i=1 → data_o=0, tc_o=0.
  - Repeat with rst_i=1 also asserted → data_o=0, all pulses 0.
- Cascade: two instances, MOD=10, stage-1 en_i = stage-0 tc_o. Run 100 enabled edges from 0.
  - Required: {stage1,stage0} reads 00..99 then 00.
  - Stage-1 wrap_o pulses once at 99->00.
- Hold and direction flip: at data_o=4, en_i=0 for 3 edges → holds 4.
  - Then alternate up_dn_i each enabled edge → 5,4,5,4.
  - No wrap_o pulses.
